uart_tx_path: RTL and testbench
===============================

# uart_tx_path

Transmit half of the serial port underneath the 65C02 ACIA register block. It accepts bytes from the ACIA data-register write strobe into a FIFO. It generates the 16x baud tick from the ACIA-selected divisor. It serialises frames (1 start, DBIT data LSB-first, 1 stop) onto `tx`, gated by the modem CTS input. The ACIA consumes `tx_full` for its status register.

## Interface
- `DBIT`, 8: data bits per frame.
- `SB_TICK`, 16: stop-bit length in baud ticks (16 = 1 stop bit).
- `FIFO_W`, 4: FIFO address width; depth = 2^FIFO_W.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  asynchronous, active-high reset.
- `wr_uart`  in  1  one-cycle write strobe; pushes `w_data`.
- `w_data`  in  DBIT  byte to transmit.
- `dvsr`  in  21  baud divisor; tick period = dvsr+1 clocks.
- `cts`  in  1  clear-to-send, active-low (0 = peer ready).
- `tx`  out  1  serial line, idle high.
- `tx_full`  out  1  FIFO full.
- `tx_empty`  out  1  FIFO empty.
- `tx_busy`  out  1  FSM not in IDLE.
- `tx_done_tick`  out  1  one-cycle pulse at end of each stop bit.

## Operation
- Reset (async, immediate, including mid-frame): `tx`=1, `tx_full`=0, `tx_empty`=1, `tx_busy`=0, `tx_done_tick`=0. FIFO pointers, baud counter, bit/tick counters and shift register are cleared. FSM goes to IDLE.
- Baud generator: 21-bit counter `bc`. `s_tick`=1 when `bc >= dvsr`, in which case `bc`←0; otherwise `bc`←`bc`+1. The `>=` compare makes a dvsr decrease mid-count wrap at once instead of rolling through 2^21. dvsr=0 gives a tick every clock.
- FIFO: 2^FIFO_W × DBIT, circular pointers, wrap at depth.
  - A write is accepted iff `wr_uart` && !`tx_full` in that cycle. Writes while full are dropped silently, even if a pop occurs in the same cycle.
  - Simultaneous accepted write and pop keeps the count unchanged.
  - `tx_full` and `tx_empty` are registered and reflect the count after the current cycle's push/pop.
- FSM states are IDLE, START, DATA, STOP. Counters: `s` (4-bit tick count) and `n` (data-bit count, 0..DBIT-1).
  - IDLE: `tx`=1. If `s_tick` && !`tx_empty` && `cts`==0: pop FIFO head into shift register, `s`←0, go to START. If cts is high, the FSM stays in IDLE indefinitely with the data kept.
  - START: `tx`=0. On each `s_tick`, `s`++. On the tick where `s`==15: `s`←0, `n`←0, go to DATA.
  - DATA: `tx`=shift[0]. On the tick where `s`==15: shift right, `s`←0. If `n`==DBIT-1 go to STOP, else `n`++.
  - STOP: `tx`=1. On the tick where `s`==SB_TICK-1: pulse `tx_done_tick`, `s`←0.
    - If !`tx_empty` && `cts`==0 in that same cycle: pop and go directly to START (back-to-back frames).
    - Otherwise go to IDLE.
- CTS is sampled only at frame-start decisions. Deasserting it mid-frame never truncates the current frame.
- `tx` is driven from a register. `tx_busy` = state ≠ IDLE.

## Timing
- A frame start occurs only on an `s_tick` cycle, so every bit boundary is tick-aligned.
- Bit durations: each start and data bit lasts exactly 16·(dvsr+1) clocks. The stop bit lasts SB_TICK·(dvsr+1) clocks.
- Latency: `tx` falls 1 clock after the IDLE/STOP cycle that pops.
- From write (FIFO empty, IDLE, cts=0) to the start bit: at most dvsr+3 clocks.
  - The write is visible as !`tx_empty` the cycle after `wr_uart`.
  - The pop then waits for the next tick.
  - `tx` falls 1 clock after the pop.
- `tx_done_tick` is high in the same cycle as the last stop tick. With back-to-back frames, the next start bit begins on the following clock, with no idle gap.
- Frame length = (16 + 16·DBIT + SB_TICK)·(dvsr+1) clocks. With defaults and dvsr=0 this is 160 clocks.

## Test plan
- Reset and idle: assert rst mid-frame → `tx`=1 in the same cycle. After release, `tx_empty`=1, `tx_full`=0, `tx_busy`=0, and `tx` stays 1 for 1000 clocks with the FIFO empty.
- Single frame: dvsr=0, cts=0, write 0x55 → `tx` low 16 clocks, then 1,0,1,0,1,0,1,0 at 16 clocks each, then high 16 clocks. `tx_done_tick` pulses once, 160 clocks after `tx` fell.
- Baud scaling: dvsr=26 (115200 at 50 MHz), write 0xA3 → each bit is 432 clocks, frame is 4320 clocks, and the decoded byte is 0xA3.
- Full FIFO and CTS hold: cts=1, write 0x00..0x10 (17 bytes) → `tx_full` goes to 1 after the 16th write, the 17th byte is dropped, and `tx` stays 1. Set cts=0 → 16 back-to-back frames 0x00..0x0F with no gap, then `tx_empty`=1 and `tx_busy`=0.
- CTS mid-frame: dvsr=0, queue 2 bytes, raise cts during the first frame's DATA state → the first frame completes intact and the second does not start until cts=0.
- Wrap-around and simultaneous push/pop: stream 40 bytes while keeping the FIFO partly full, with writes landing on pop cycles → every byte is transmitted in order, with no loss or duplication across pointer wrap.

Source files
------------

// File: rtl/uart_tx_path.sv
// UART transmit path: write FIFO, 16x oversampling baud generator and a frame
// serialiser that only starts a frame while the active-low CTS input is asserted.
module uart_tx_path #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int FIFO_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_uart,
  input  logic [DBIT-1:0] w_data,
  input  logic [20:0]     dvsr,
  input  logic            cts,
  output logic            tx,
  output logic            tx_full,
  output logic            tx_empty,
  output logic            tx_busy,
  output logic            tx_done_tick
);
  localparam int NW    = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int DEPTH = 1 << FIFO_W;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [20:0]       bc_q, bc_d;
  logic              s_tick;

  logic [DBIT-1:0]   mem_q [DEPTH];
  logic [FIFO_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic              full_q, full_d, empty_q, empty_d;
  logic              push, pop;

  state_t            state_q, state_d;
  logic [3:0]        s_q, s_d;
  logic [NW-1:0]     n_q, n_d;
  logic [DBIT-1:0]   shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              done_d;

  // Baud generator: >= lets a lowered divisor take effect immediately.
  always_comb begin
    s_tick = (bc_q >= dvsr);
    bc_d   = s_tick ? '0 : bc_q + 21'd1;
  end

  assign push = wr_uart && !full_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    if (push) wptr_d = wptr_q + FIFO_W'(1);
    if (pop)  rptr_d = rptr_q + FIFO_W'(1);
    case ({push, pop})
      2'b10: begin
        empty_d = 1'b0;
        full_d  = ((wptr_q + FIFO_W'(1)) == rptr_q);
      end
      2'b01: begin
        full_d  = 1'b0;
        empty_d = ((rptr_q + FIFO_W'(1)) == wptr_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= w_data;
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shift_d = shift_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_tick && !empty_q && !cts) begin
          pop     = 1'b1;
          shift_d = mem_q[rptr_q];
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == 4'd15) begin
            s_d     = '0;
            shift_d = shift_q >> 1;
            if (n_q == NW'(DBIT - 1)) state_d = STOP;
            else                      n_d = n_q + NW'(1);
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == 4'(SB_TICK - 1)) begin
            done_d = 1'b1;
            s_d    = '0;
            // Chain straight into the next start bit so streamed frames have no idle gap.
            if (!empty_q && !cts) begin
              pop     = 1'b1;
              shift_d = mem_q[rptr_q];
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bc_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      bc_q    <= bc_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign tx           = tx_q;
  assign tx_full      = full_q;
  assign tx_empty     = empty_q;
  assign tx_busy      = (state_q != IDLE);
  assign tx_done_tick = done_d;

endmodule

// File: tb/tb_uart_tx_path.sv
// Bench for uart_tx_path: a bit-timing receiver model decodes tx and the
// scenarios compare decoded bytes, flags and timing against a byte-queue model.
`timescale 1ns/1ps
module tb_uart_tx_path;
  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int DEPTH   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_uart = 1'b0;
  logic        cts = 1'b0;
  logic [7:0]  w_data = '0;
  logic [20:0] dvsr = '0;
  logic        tx, tx_full, tx_empty, tx_busy, tx_done_tick;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  uart_tx_path #(.DBIT(DBIT), .SB_TICK(SB_TICK), .FIFO_W(4)) dut (
    .clk(clk), .rst(rst), .wr_uart(wr_uart), .w_data(w_data), .dvsr(dvsr),
    .cts(cts), .tx(tx), .tx_full(tx_full), .tx_empty(tx_empty),
    .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Receiver model: every bit is 16*(dvsr+1) clocks, must be constant across
  // its whole duration, start=0, stop=1, done pulse only in the frame's last clock.
  bit            mon_active = 0;
  int            mon_t = 0, mon_bit_len = 16, mon_frame_len = 160;
  logic [DBIT+1:0] mon_bits;
  int            glitches = 0, bad_frames = 0, bad_done = 0, done_ticks = 0;
  int            frames_started = 0, b2b = 0;
  int            last_end_cyc = -10, last_start_cyc = 0, last_done_cyc = 0;

  always @(negedge clk) begin
    int idx;
    if (rst) begin
      mon_active = 0;
    end else begin
      if (tx_done_tick === 1'b1) begin
        done_ticks++;
        last_done_cyc = cyc;
        if (!(mon_active && mon_t == mon_frame_len - 1)) bad_done++;
      end
      if (!mon_active && tx === 1'b0) begin
        mon_active     = 1;
        mon_t          = 0;
        mon_bit_len    = 16 * (int'(dvsr) + 1);
        mon_frame_len  = (16 + 16 * DBIT + SB_TICK) * (int'(dvsr) + 1);
        frames_started++;
        if (cyc == last_end_cyc + 1) b2b++;
        last_start_cyc = cyc;
      end
      if (mon_active) begin
        idx = mon_t / mon_bit_len;
        if (idx > DBIT + 1) idx = DBIT + 1;
        if (mon_t % mon_bit_len == 0) mon_bits[idx] = tx;
        else if (tx !== mon_bits[idx]) glitches++;
        if (mon_t == mon_frame_len - 1) begin
          if (mon_bits[0] !== 1'b0 || mon_bits[DBIT+1] !== 1'b1) bad_frames++;
          rx_q.push_back(mon_bits[DBIT:1]);
          last_end_cyc = cyc;
          mon_active   = 0;
        end else begin
          mon_t++;
        end
      end
    end
  end

  task automatic do_write(input logic [7:0] b, output int wcyc);
    @(negedge clk);
    wr_uart = 1'b1;
    w_data  = b;
    wcyc    = cyc;
    @(negedge clk);
    wr_uart = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int k = 0;
    ok = 0;
    while (k < budget && !ok) begin
      @(negedge clk); #1;
      if (rx_q.size() >= n) ok = 1;
      k++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    total_cnt++; if (tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx); else pass_cnt++;
    total_cnt++; if (tx_full !== 1'b0) $display("FAIL reset_full: got %b want 0", tx_full); else pass_cnt++;
    total_cnt++; if (tx_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", tx_empty); else pass_cnt++;
    total_cnt++; if (tx_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", tx_busy); else pass_cnt++;
    total_cnt++; if (tx_done_tick !== 1'b0) $display("FAIL reset_done: got %b want 0", tx_done_tick); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single_frame;
    int wcyc, d0, g0, bf0, bd0;
    bit ok;
    dvsr = 21'd0; cts = 1'b0;
    rx_q.delete();
    d0 = done_ticks; g0 = glitches; bf0 = bad_frames; bd0 = bad_done;
    do_write(8'h55, wcyc);
    wait_rx(1, 400, ok);
    total_cnt++; if (!ok) $display("FAIL single_timeout: got %0d frames want 1", rx_q.size()); else pass_cnt++;
    if (ok) begin
      total_cnt++; if (rx_q[0] !== 8'h55) $display("FAIL single_data: got %h want 55", rx_q[0]); else pass_cnt++;
    end
    total_cnt++; if (last_start_cyc - wcyc > 3) $display("FAIL single_latency: got %0d want <=3", last_start_cyc - wcyc); else pass_cnt++;
    total_cnt++; if (glitches != g0 || bad_frames != bf0) $display("FAIL single_shape: got glitches %0d bad %0d want %0d %0d", glitches, bad_frames, g0, bf0); else pass_cnt++;
    total_cnt++; if (done_ticks - d0 != 1) $display("FAIL single_done_count: got %0d want 1", done_ticks - d0); else pass_cnt++;
    // Done pulse sits in the 160th (last) clock of the frame.
    total_cnt++; if (last_done_cyc - last_start_cyc != 159) $display("FAIL single_done_pos: got %0d want 159", last_done_cyc - last_start_cyc); else pass_cnt++;
    total_cnt++; if (bad_done != bd0) $display("FAIL single_done_stray: got %0d want %0d", bad_done, bd0); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (tx_busy !== 1'b0 || tx !== 1'b1) $display("FAIL single_idle: got busy %b tx %b want 0 1", tx_busy, tx); else pass_cnt++;
  endtask

  task automatic test_baud_scaling;
    int wcyc, g0, bf0;
    bit ok;
    dvsr = 21'd26; cts = 1'b0;
    rx_q.delete();
    g0 = glitches; bf0 = bad_frames;
    do_write(8'hA3, wcyc);
    wait_rx(1, 4500, ok);
    total_cnt++; if (!ok) $display("FAIL baud_timeout: got %0d frames want 1", rx_q.size()); else pass_cnt++;
    if (ok) begin
      total_cnt++; if (rx_q[0] !== 8'hA3) $display("FAIL baud_data: got %h want a3", rx_q[0]); else pass_cnt++;
    end
    total_cnt++; if (last_done_cyc - last_start_cyc + 1 != 4320) $display("FAIL baud_frame_len: got %0d want 4320", last_done_cyc - last_start_cyc + 1); else pass_cnt++;
    total_cnt++; if (last_start_cyc - wcyc > 29) $display("FAIL baud_latency: got %0d want <=29", last_start_cyc - wcyc); else pass_cnt++;
    total_cnt++; if (glitches != g0 || bad_frames != bf0) $display("FAIL baud_shape: got glitches %0d bad %0d want %0d %0d", glitches, bad_frames, g0, bf0); else pass_cnt++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_random_frames;
    int wcyc, g0, d;
    bit ok;
    logic [7:0] b;
    cts = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d = int'($urandom_range(0, 4));
      dvsr = 21'(d);
      b = 8'($urandom);
      rx_q.delete();
      g0 = glitches;
      do_write(b, wcyc);
      wait_rx(1, 200 * (d + 1) + 50, ok);
      total_cnt++; if (!ok || rx_q[0] !== b) $display("FAIL rand_data_%0d: got %h want %h (dvsr %0d)", i, ok ? rx_q[0] : 8'hxx, b, d); else pass_cnt++;
      total_cnt++; if (last_done_cyc - last_start_cyc + 1 != 160 * (d + 1) || glitches != g0) $display("FAIL rand_len_%0d: got %0d glitches %0d want %0d 0", i, last_done_cyc - last_start_cyc + 1, glitches - g0, 160 * (d + 1)); else pass_cnt++;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_full_cts;
    int wcyc, b0, lows;
    bit ok;
    dvsr = 21'd0; cts = 1'b1;
    rx_q.delete(); exp_q.delete();
    for (int i = 0; i <= 16; i++) begin
      do_write(8'(i), wcyc);
      if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
      total_cnt++; if (tx_full !== (exp_q.size() == DEPTH)) $display("FAIL full_flag_%0d: got %b want %b", i, tx_full, exp_q.size() == DEPTH); else pass_cnt++;
    end
    lows = 0;
    repeat (50) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    total_cnt++; if (lows != 0 || tx_busy !== 1'b0 || tx_empty !== 1'b0) $display("FAIL cts_hold: got lows %0d busy %b empty %b want 0 0 0", lows, tx_busy, tx_empty); else pass_cnt++;
    b0 = b2b;
    cts = 1'b0;
    wait_rx(16, 16 * 160 + 300, ok);
    total_cnt++; if (!ok) $display("FAIL full_timeout: got %0d frames want 16", rx_q.size()); else pass_cnt++;
    for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
      total_cnt++; if (rx_q[i] !== exp_q[i]) $display("FAIL full_order_%0d: got %h want %h", i, rx_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (b2b - b0 != 15) $display("FAIL full_b2b: got %0d want 15", b2b - b0); else pass_cnt++;
    repeat (300) @(negedge clk);
    total_cnt++; if (rx_q.size() != 16) $display("FAIL full_drop: got %0d frames want 16", rx_q.size()); else pass_cnt++;
    total_cnt++; if (tx_empty !== 1'b1 || tx_busy !== 1'b0) $display("FAIL full_drain: got empty %b busy %b want 1 0", tx_empty, tx_busy); else pass_cnt++;
  endtask

  task automatic test_cts_midframe;
    int wcyc, s0, k, g0;
    bit ok;
    dvsr = 21'd0; cts = 1'b0;
    rx_q.delete();
    g0 = glitches;
    s0 = frames_started;
    do_write(8'h5A, wcyc);
    do_write(8'hC3, wcyc);
    k = 0;
    while (frames_started == s0 && k < 100) begin @(negedge clk); k++; end
    repeat (40) @(negedge clk);
    cts = 1'b1;
    repeat (400) @(negedge clk);
    #1;
    total_cnt++; if (rx_q.size() != 1 || rx_q[0] !== 8'h5A) $display("FAIL cts_first: got %0d frames first %h want 1 5a", rx_q.size(), rx_q.size() > 0 ? rx_q[0] : 8'hxx); else pass_cnt++;
    total_cnt++; if (frames_started - s0 != 1 || tx_busy !== 1'b0 || tx_empty !== 1'b0) $display("FAIL cts_held: got starts %0d busy %b empty %b want 1 0 0", frames_started - s0, tx_busy, tx_empty); else pass_cnt++;
    cts = 1'b0;
    wait_rx(2, 400, ok);
    total_cnt++; if (!ok || rx_q[1] !== 8'hC3) $display("FAIL cts_second: got %0d frames want 2 with c3", rx_q.size()); else pass_cnt++;
    total_cnt++; if (glitches != g0) $display("FAIL cts_shape: got %0d glitches want 0", glitches - g0); else pass_cnt++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap_stream;
    int sent, fs0, occ, k, g0, bf0, pop_writes;
    dvsr = 21'd0; cts = 1'b0;
    rx_q.delete(); exp_q.delete();
    sent = 0; k = 0; pop_writes = 0;
    fs0 = frames_started; g0 = glitches; bf0 = bad_frames;
    while (rx_q.size() < 40 && k < 40 * 160 + 3000) begin
      @(negedge clk);
      wr_uart = 1'b0;
      occ = sent - (frames_started - fs0);
      if (sent < 40 && occ < DEPTH - 1 &&
          (tx_done_tick === 1'b1 || (occ < 4 && $urandom_range(0, 3) == 0))) begin
        if (tx_done_tick === 1'b1) pop_writes++;
        wr_uart = 1'b1;
        w_data  = 8'($urandom);
        exp_q.push_back(w_data);
        sent++;
      end
      k++;
    end
    wr_uart = 1'b0;
    total_cnt++; if (rx_q.size() != 40) $display("FAIL wrap_count: got %0d frames want 40", rx_q.size()); else pass_cnt++;
    for (int i = 0; i < 40 && i < rx_q.size(); i++) begin
      total_cnt++; if (rx_q[i] !== exp_q[i]) $display("FAIL wrap_order_%0d: got %h want %h", i, rx_q[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (glitches != g0 || bad_frames != bf0) $display("FAIL wrap_shape: got glitches %0d bad %0d want 0 0", glitches - g0, bad_frames - bf0); else pass_cnt++;
    repeat (300) @(negedge clk);
    total_cnt++; if (rx_q.size() != 40 || tx_empty !== 1'b1 || tx_busy !== 1'b0) $display("FAIL wrap_drain: got %0d frames empty %b busy %b want 40 1 0", rx_q.size(), tx_empty, tx_busy); else pass_cnt++;
    if (pop_writes == 0) $display("note: no write coincided with a pop cycle");
  endtask

  task automatic test_reset_midframe;
    int wcyc, s0, k, lows;
    dvsr = 21'd0; cts = 1'b0;
    rx_q.delete();
    s0 = frames_started;
    do_write(8'h00, wcyc);
    do_write(8'h00, wcyc);
    k = 0;
    while (frames_started == s0 && k < 100) begin @(negedge clk); k++; end
    repeat (40) @(negedge clk);
    total_cnt++; if (tx !== 1'b0) $display("FAIL midframe_low: got %b want 0", tx); else pass_cnt++;
    #3 rst = 1'b1;
    #1;
    total_cnt++; if (tx !== 1'b1 || tx_busy !== 1'b0) $display("FAIL async_reset: got tx %b busy %b want 1 0", tx, tx_busy); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    total_cnt++; if (tx_empty !== 1'b1 || tx_full !== 1'b0 || tx_busy !== 1'b0) $display("FAIL post_reset_flags: got empty %b full %b busy %b want 1 0 0", tx_empty, tx_full, tx_busy); else pass_cnt++;
    lows = 0;
    repeat (1000) begin @(negedge clk); if (tx !== 1'b1) lows++; end
    total_cnt++; if (lows != 0) $display("FAIL idle_1000: got %0d low clocks want 0", lows); else pass_cnt++;
    total_cnt++; if (tx_empty !== 1'b1 || tx_busy !== 1'b0) $display("FAIL idle_flags: got empty %b busy %b want 1 0", tx_empty, tx_busy); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_baud_scaling();
    test_random_frames();
    test_full_cts();
    test_cts_midframe();
    test_wrap_stream();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
